// File: rtl/rtc_pkg.sv
// ----------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC read sequencer:
//   rtc_state_t : sequencer FSM states
//   RTC_ADDR    : RTC register addresses read per sweep, index 0..8
//   EN_BASE     : first en[] bit driven by the sequencer (en bit = index + 2)
//   EN_WIDTH    : width of the load-enable vector toward the register bank
//   PHASE_W     : width of the bus-phase timer (T_PHASE up to 15)
//   IDX_W       : width of the register index
// ----------------------------------------------------------------------------
package rtc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      READ,
      LATCH,
      GAP,
      DONE
   } rtc_state_t;

   localparam int N_ADDR   = 9;
   localparam int EN_BASE  = 2;
   localparam int EN_WIDTH = 13;
   localparam int PHASE_W  = 4;
   localparam int IDX_W    = 4;

   // Index 0 is the leftmost entry of the packed array.
   localparam logic [0:N_ADDR-1][7:0] RTC_ADDR = {
      8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
      8'h41, 8'h42, 8'h43
   };

endpackage

// File: rtl/phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter timing one bus phase. Loading N makes tc assert in the
// (N+1)-th cycle after the load edge; the counter then rests at zero.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-low reset
//   load     : reload the counter with load_val on this edge
//   load_val : reload value (phase length minus one)
//   tc       : terminal count, high while the counter is zero
// ----------------------------------------------------------------------------
module phase_timer
   import rtc_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [PHASE_W-1:0] load_val,
   output logic               tc
);

   logic [PHASE_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/rtc_read_sequencer.sv
// ----------------------------------------------------------------------------
// rtc_read_sequencer
// On a start pulse, reads the nine RTC time/timer registers over the RTC's
// multiplexed address/data bus and hands each byte to the register bank on
// `entrada` with a one-cycle one-hot load enable en[2]..en[10].
// Each register takes ADDR (T_PHASE) + READ (T_PHASE) + LATCH (1) + GAP
// (T_PHASE) cycles; a DONE cycle closes the sweep.
//
// Optional build macro RTC_READ_BCD_CHECK_EN: when defined, a sticky bcd_err
// flags any captured byte with a nibble above 9 (cleared by reset or an
// accepted start). When undefined, bcd_err is tied low.
//
// Parameters:
//   T_PHASE : clk cycles per bus phase, 2..15
//   N_REGS  : registers per sweep, equal to the address-table length (9)
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   start           : one-cycle sweep request, honoured only in IDLE
//   busy, done      : sweep in progress / one-cycle end-of-sweep pulse
//   rtc_cs_n/rd_n/wr_n, rtc_a_d, rtc_ad_out, rtc_ad_oe : RTC bus controls
//   rtc_ad_in       : RTC bus read-back
//   entrada         : last byte read (held between reads)
//   en              : one-hot load enables, bits 2..10 used here
//   bcd_err         : sticky BCD error flag
// ----------------------------------------------------------------------------
module rtc_read_sequencer
   import rtc_pkg::*;
#(
   parameter int T_PHASE = 4,
   parameter int N_REGS  = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                rtc_cs_n,
   output logic                rtc_rd_n,
   output logic                rtc_wr_n,
   output logic                rtc_a_d,
   output logic [7:0]          rtc_ad_out,
   output logic                rtc_ad_oe,
   input  logic [7:0]          rtc_ad_in,
   output logic [7:0]          entrada,
   output logic [EN_WIDTH-1:0] en,
   output logic                bcd_err
);

   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_REGS - 1);
   localparam logic [PHASE_W-1:0] PHASE_LOAD = PHASE_W'(T_PHASE - 1);
   localparam logic [EN_WIDTH-1:0] EN_ONE    = EN_WIDTH'(1);

   rtc_state_t       state;
   logic [IDX_W-1:0] idx;
   logic             tmr_load;
   logic             tmr_tc;

`ifdef RTC_READ_BCD_CHECK_EN
   function automatic logic bcd_bad(input logic [7:0] b);
      return (b[7:4] > 4'h9) || (b[3:0] > 4'h9);
   endfunction
`endif

   // The timer is reloaded on every edge that enters a T_PHASE-long phase.
   always_comb begin
      tmr_load = 1'b0;
      unique case (state)
         IDLE:    tmr_load = start;
         ADDR:    tmr_load = tmr_tc;
         LATCH:   tmr_load = 1'b1;
         GAP:     tmr_load = tmr_tc && (idx != LAST_IDX);
         default: tmr_load = 1'b0;
      endcase
   end

   phase_timer u_phase_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (PHASE_LOAD),
      .tc       (tmr_tc)
   );

   // Outputs are registered: every transition edge also sets the bus levels
   // of the state being entered.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rtc_cs_n   <= 1'b1;
         rtc_rd_n   <= 1'b1;
         rtc_wr_n   <= 1'b1;
         rtc_a_d    <= 1'b0;
         rtc_ad_oe  <= 1'b0;
         rtc_ad_out <= 8'h00;
         entrada    <= 8'h00;
         en         <= '0;
`ifdef RTC_READ_BCD_CHECK_EN
         bcd_err    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         en   <= '0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state      <= ADDR;
                  idx        <= '0;
                  busy       <= 1'b1;
                  rtc_cs_n   <= 1'b0;
                  rtc_wr_n   <= 1'b0;
                  rtc_a_d    <= 1'b0;
                  rtc_ad_oe  <= 1'b1;
                  rtc_ad_out <= RTC_ADDR[0];
`ifdef RTC_READ_BCD_CHECK_EN
                  bcd_err    <= 1'b0;
`endif
               end
            end
            ADDR: begin
               if (tmr_tc) begin
                  state     <= READ;
                  rtc_wr_n  <= 1'b1;
                  rtc_rd_n  <= 1'b0;
                  rtc_a_d   <= 1'b1;
                  rtc_ad_oe <= 1'b0;
               end
            end
            READ: begin
               if (tmr_tc) begin
                  state    <= LATCH;
                  rtc_cs_n <= 1'b1;
                  rtc_rd_n <= 1'b1;
                  rtc_a_d  <= 1'b0;
                  entrada  <= rtc_ad_in;
                  en       <= EN_ONE << (int'(idx) + EN_BASE);
`ifdef RTC_READ_BCD_CHECK_EN
                  if (bcd_bad(rtc_ad_in)) begin
                     bcd_err <= 1'b1;
                  end
`endif
               end
            end
            LATCH: begin
               state <= GAP;
            end
            GAP: begin
               if (tmr_tc) begin
                  if (idx == LAST_IDX) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state      <= ADDR;
                     idx        <= idx + 1'b1;
                     rtc_cs_n   <= 1'b0;
                     rtc_wr_n   <= 1'b0;
                     rtc_ad_oe  <= 1'b1;
                     rtc_ad_out <= RTC_ADDR[idx + 1'b1];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifndef RTC_READ_BCD_CHECK_EN
   assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rtc_read_sequencer
// Self-checking bench for rtc_read_sequencer. A behavioural RTC model answers
// reads from a byte memory; expected per-cycle behaviour of a sweep is derived
// from the sweep timing (3*T+1 cycles per register plus a done cycle).
// ----------------------------------------------------------------------------
module tb_rtc_read_sequencer;

   localparam int T   = 4;
   localparam int PER = 3 * T + 1;
   localparam int NCY = 9 * PER + 1;

`ifdef RTC_READ_BCD_CHECK_EN
   localparam bit BCD_ON = 1'b1;
`else
   localparam bit BCD_ON = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic        rtc_cs_n;
   logic        rtc_rd_n;
   logic        rtc_wr_n;
   logic        rtc_a_d;
   logic [7:0]  rtc_ad_out;
   logic        rtc_ad_oe;
   logic [7:0]  rtc_ad_in;
   logic [7:0]  entrada;
   logic [12:0] en;
   logic        bcd_err;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem [0:255];
   logic [7:0] addr_tab [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                  8'h41, 8'h42, 8'h43};
   logic [7:0] lat_addr;
   logic [7:0] last_byte;
   logic       last_err;

   rtc_read_sequencer #(.T_PHASE(T), .N_REGS(9)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .rtc_cs_n   (rtc_cs_n),
      .rtc_rd_n   (rtc_rd_n),
      .rtc_wr_n   (rtc_wr_n),
      .rtc_a_d    (rtc_a_d),
      .rtc_ad_out (rtc_ad_out),
      .rtc_ad_oe  (rtc_ad_oe),
      .rtc_ad_in  (rtc_ad_in),
      .entrada    (entrada),
      .en         (en),
      .bcd_err    (bcd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RTC model: latches the address during a write-strobed address cycle and
   // returns the stored byte while the read strobe is low.
   always @(posedge clk) begin
      if (!rtc_cs_n && !rtc_wr_n && !rtc_a_d && rtc_ad_oe)
         lat_addr <= rtc_ad_out;
   end

   always_comb begin
      rtc_ad_in = 8'hEE;
      if (!rtc_cs_n && !rtc_rd_n)
         rtc_ad_in = mem[lat_addr];
   end

   function automatic bit bcd_bad(input logic [7:0] b);
      return (b[7:4] > 4'h9) || (b[3:0] > 4'h9);
   endfunction

   task automatic kick();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic fill_random(input bit bcd_only);
      for (int i = 0; i < 9; i++) begin
         if (bcd_only)
            mem[addr_tab[i]] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         else
            mem[addr_tab[i]] = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic check_idle(input string tag);
      checks++;
      if ({rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_a_d, rtc_ad_oe} !== 5'b11100) begin
         errors++;
         $display("FAIL %s bus got=%b exp=%b", tag,
                  {rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_a_d, rtc_ad_oe}, 5'b11100);
      end
      checks++;
      if (en !== 13'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s en/busy/done got=%h/%b/%b exp=0/0/0", tag, en, busy, done);
      end
   endtask

   // Called right after the accept edge; checks every cycle of the sweep and
   // the first cycle after it.
   task automatic check_sweep(input string tag, input bit extra, input bit at_done,
                              input bit b2b);
      int r, p, k;
      logic [4:0]  exp_bus;
      logic [12:0] exp_en;
      logic [7:0]  exp_ent;
      logic        exp_err;
      logic        exp_done;
      for (int c = 0; c < NCY; c++) begin
         @(negedge clk);
         r = c / PER;
         p = c % PER;
         exp_done = (c == NCY - 1);
         if (exp_done)      exp_bus = 5'b11100;
         else if (p < T)    exp_bus = 5'b00101;
         else if (p < 2*T)  exp_bus = 5'b01010;
         else               exp_bus = 5'b11100;
         exp_en = (!exp_done && p == 2*T) ? (13'd1 << (r + 2)) : 13'd0;
         k = exp_done ? 9 : r + ((p >= 2*T) ? 1 : 0);
         exp_ent = (k == 0) ? last_byte : mem[addr_tab[k-1]];
         exp_err = 1'b0;
         for (int j = 0; j < k; j++)
            if (BCD_ON && bcd_bad(mem[addr_tab[j]])) exp_err = 1'b1;

         checks++;
         if ({rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_a_d, rtc_ad_oe} !== exp_bus) begin
            errors++;
            $display("FAIL %s bus c=%0d got=%b exp=%b", tag, c,
                     {rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_a_d, rtc_ad_oe}, exp_bus);
         end
         if (!exp_done && p < T) begin
            checks++;
            if (rtc_ad_out !== addr_tab[r]) begin
               errors++;
               $display("FAIL %s ad_out c=%0d got=%h exp=%h", tag, c, rtc_ad_out, addr_tab[r]);
            end
         end
         checks++;
         if (en !== exp_en) begin
            errors++;
            $display("FAIL %s en c=%0d got=%h exp=%h", tag, c, en, exp_en);
         end
         checks++;
         if (entrada !== exp_ent) begin
            errors++;
            $display("FAIL %s entrada c=%0d got=%h exp=%h", tag, c, entrada, exp_ent);
         end
         checks++;
         if (busy !== 1'b1 || done !== exp_done) begin
            errors++;
            $display("FAIL %s busy/done c=%0d got=%b/%b exp=1/%b", tag, c, busy, done, exp_done);
         end
         checks++;
         if (bcd_err !== exp_err) begin
            errors++;
            $display("FAIL %s bcd_err c=%0d got=%b exp=%b", tag, c, bcd_err, exp_err);
         end
         start = (extra && (c == 5 || c == 60)) || (at_done && c == NCY - 1);
         last_err = exp_err;
      end
      last_byte = mem[addr_tab[8]];
      @(negedge clk);
      check_idle({tag, "_after"});
      checks++;
      if (entrada !== last_byte || bcd_err !== last_err) begin
         errors++;
         $display("FAIL %s hold got=%h/%b exp=%h/%b", tag, entrada, bcd_err, last_byte, last_err);
      end
      start = b2b;
      if (b2b) begin
         @(posedge clk);
         #1 start = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      checks++;
      if (entrada !== 8'h00 || rtc_ad_out !== 8'h00 || bcd_err !== 1'b0) begin
         errors++;
         $display("FAIL reset data got=%h/%h/%b exp=00/00/0", entrada, rtc_ad_out, bcd_err);
      end
      reset = 1'b1;
      last_byte = 8'h00;
   endtask

   task automatic test_directed_sweep();
      mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h59;
      mem[8'h24] = 8'h23; mem[8'h25] = 8'h31; mem[8'h26] = 8'h12;
      mem[8'h41] = 8'h07; mem[8'h42] = 8'h19; mem[8'h43] = 8'h12;
      kick();
      check_sweep("directed", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random_sweeps();
      for (int n = 0; n < 2; n++) begin
         fill_random(1'b0);
         kick();
         check_sweep("random", 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_ignored_start();
      fill_random(1'b1);
      kick();
      check_sweep("ignored_start", 1'b1, 1'b1, 1'b0);
      repeat (5) begin
         @(negedge clk);
         check_idle("ignored_start_idle");
      end
   endtask

   task automatic test_back_to_back();
      fill_random(1'b1);
      kick();
      check_sweep("b2b_first", 1'b0, 1'b0, 1'b1);
      fill_random(1'b0);
      check_sweep("b2b_second", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_bcd();
      fill_random(1'b1);
      mem[8'h23] = 8'h5A;
      kick();
      check_sweep("bcd_bad", 1'b0, 1'b0, 1'b0);
      fill_random(1'b1);
      kick();
      check_sweep("bcd_clear", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_sweep();
      fill_random(1'b1);
      kick();
      repeat (30) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle("mid_reset");
      checks++;
      if (entrada !== 8'h00 || bcd_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset data got=%h/%b exp=00/0", entrada, bcd_err);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      last_byte = 8'h00;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_idle("post_reset");
      end
      fill_random(1'b0);
      kick();
      check_sweep("after_reset", 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_directed_sweep();
      test_random_sweeps();
      test_ignored_start();
      test_back_to_back();
      test_bcd();
      test_reset_mid_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rtc_read_sequencer.md
Name: rtc_read_sequencer

Overview:
- Upstream feeder of the input register bank.
- On a start pulse, reads the nine RTC time/timer registers over the RTC's multiplexed address/data bus.
- For each register read, presents the byte on `entrada` and pulses the matching one-hot enable bit, `en[2]`..`en[10]`, for exactly one cycle.
- Bits `en[0]`, `en[1]`, `en[11]`, `en[12]` belong to other sources and are driven 0 here.

Parameters:
- T_PHASE, 4, clk cycles per bus phase (address, read, gap); legal range 2..15.
- N_REGS, 9, number of registers read per sweep; fixed to the address-table length.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a sweep
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse after the last register is latched
- rtc_cs_n  out  1  RTC chip select, active low
- rtc_rd_n  out  1  RTC read strobe, active low
- rtc_wr_n  out  1  RTC write strobe, active low (address phase only)
- rtc_a_d  out  1  0 = address cycle, 1 = data cycle
- rtc_ad_out  out  8  address driven on the bus
- rtc_ad_oe  out  1  1 = drive rtc_ad_out onto the pad
- rtc_ad_in  in  8  bus read-back
- entrada  out  8  last byte read
- en  out  13  one-hot load enables toward the register bank
- bcd_err  out  1  sticky BCD error flag (see Optional Feature)

Behaviour:
- Reset (reset==0 at a clk edge) values:
  - rtc_cs_n = rtc_rd_n = rtc_wr_n = 1
  - rtc_a_d = 0, rtc_ad_oe = 0, rtc_ad_out = 8'h00
  - entrada = 8'h00, en = 0, busy = 0, done = 0, bcd_err = 0
  - state = IDLE, index = 0
- Reset mid-sweep aborts: the bus returns inactive on that edge and no en pulse follows.
- All outputs are registered.
- Address table, index 0..8:
  - 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26 load en[2..7]
  - 8'h41, 8'h42, 8'h43 load en[8..10]
  - en bit = index + 2.
- FSM states: IDLE, ADDR, READ, LATCH, GAP, DONE. The phase counter runs 0..T_PHASE-1.
- IDLE:
  - All strobes are high.
  - start==1 → ADDR, with index = 0 and busy = 1.
- ADDR, T_PHASE cycles:
  - cs_n = 0, wr_n = 0, a_d = 0, ad_oe = 1, ad_out = table[index].
  - Counter reaching T_PHASE-1 → READ.
- READ, T_PHASE cycles:
  - cs_n = 0, rd_n = 0, a_d = 1, ad_oe = 0.
  - rtc_ad_in is captured into entrada on the edge ending the final cycle.
  - Then → LATCH.
- LATCH, 1 cycle:
  - All strobes high; en[index+2] = 1; entrada is stable.
  - → GAP.
- GAP, T_PHASE cycles:
  - Strobes high, en = 0.
  - If index == N_REGS-1 → DONE; otherwise index++ and → ADDR.
- DONE, 1 cycle:
  - done = 1, busy = 1 in this cycle.
  - → IDLE, with busy = 0 from the next cycle.
- Timing:
  - Per-register period is 3*T_PHASE + 1 cycles (13 at the default).
  - A full sweep from the start-accept edge to the done pulse is 9*13 + 1 = 118 cycles at the default.
- start while not in IDLE is ignored; there is no queueing.
- start and done in the same cycle: start is ignored (the state is DONE).
- At most one en bit is high in any cycle; en is never high outside LATCH.
- entrada holds its value between reads.

Optional Feature:
- Macro: RTC_READ_BCD_CHECK_EN.
- Defined:
  - At each READ capture, if either nibble of rtc_ad_in is > 4'h9, bcd_err is set.
  - bcd_err is sticky and cleared only by reset or by an accepted start.
  - Data is still latched unchanged.
- Undefined: bcd_err is tied to 0 and no checking logic is generated.

Decomposition:
- Shared package `rtc_pkg`:
  - FSM state enum
  - RTC_ADDR table constant (9 × 8-bit)
  - EN_BASE = 2
  - EN_WIDTH = 13
- One sub-module: `phase_timer` (loadable down-counter with terminal-count output), instanced once and reloaded at each phase entry.

Test Plan:
- Reset held low for 3 cycles, mid-sweep → next edge: strobes all 1, en = 0, busy = 0; no en pulse for 20 cycles after release without start.
- start, RTC model returns 8'h45 at 8'h21 … 8'h12 at 8'h43 → en[2]..en[10] each pulse once, in order, 13 cycles apart; entrada equals the model byte during each pulse; done fires 118 cycles after start.
- Bus protocol check → ADDR: a_d = 0, wr_n = 0, ad_oe = 1, ad_out = 8'h21 for 4 cycles. READ: a_d = 1, rd_n = 0, ad_oe = 0 for 4 cycles. cs_n is high during GAP.
- start re-pulsed at cycles 5 and 60 of a sweep → ignored; exactly 9 en pulses and 1 done.
- Back-to-back sweeps, start asserted the cycle after done → second sweep begins; busy is low for exactly that one cycle.
- With RTC_READ_BCD_CHECK_EN, model returns 8'h5A for 8'h23 → bcd_err = 1 from the READ capture onward, stays 1 through done, clears on the next accepted start; en[4] still pulses with entrada = 8'h5A.
